ps_boot_ctrl: RTL and testbench
===============================

Name: ps_boot_ctrl

Overview:
Harness and memory subsystem that sits directly upstream of pipelinedPS. It owns the instruction memory (IM) and data memory (DM) arrays and serves the processor's im_*/dm_* ports. It loads both arrays from a host word stream, pulses start, and waits for stop under a watchdog. It then streams a window of DM back to the host, so silicon and FPGA runs can check results the same way the simulation bench does.

Parameters:
ADDR_WIDTH, 8, IM/DM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 16, word width
TIMEOUT, 1000000, max RUN cycles before timeout_err

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
go  in  1  1-cycle pulse; accepted only in IDLE or DONE
cfg_im_words  in  ADDR_WIDTH+1  IM words to load, sampled on go
cfg_dm_words  in  ADDR_WIDTH+1  DM words to load, sampled on go
cfg_dump_words  in  ADDR_WIDTH+1  DM words to dump, starting at address 0, sampled on go
ld_valid  in  1  host load word valid
ld_data  in  DATA_WIDTH  host load word
ld_ready  out  1  block accepts ld_data
out_valid  out  1  dump word valid
out_data  out  DATA_WIDTH  dump word
out_ready  in  1  host accepts dump word
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
timeout_err  out  1  sticky; set on watchdog expiry; cleared on the next accepted go
run_cycles  out  32  cycles spent in RUN, saturating
ps_start  out  1  processor start pulse
ps_stop  in  1  processor stop
im_addr  in  ADDR_WIDTH  processor IM address
im_rd  in  1  processor IM read enable
im_r_data  out  DATA_WIDTH  IM read data
dm_addr  in  ADDR_WIDTH  processor DM address
dm_rd  in  1  processor DM read enable
dm_wr  in  1  processor DM write enable
dm_w_data  in  DATA_WIDTH  processor DM write data
dm_r_data  out  DATA_WIDTH  DM read data

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Array contents are not reset.
- States: IDLE -> LOAD_IM -> LOAD_DM -> START -> RUN -> DUMP_RD <-> DUMP_OUT -> DONE. DONE -> LOAD_IM on go.
- go accepted: latch the cfg words, each clamped to 2**ADDR_WIDTH; clear timeout_err and run_cycles; enter LOAD_IM.
- LOAD_IM / LOAD_DM:
  - ld_ready=1. On each ld_valid&ld_ready, write the word at the counter address and increment the counter.
  - Leave the state after the last word.
  - A zero count skips the state in 0 cycles; the transition is decided combinationally from the latched count.
- START: ps_start=1 for exactly one cycle, then RUN.
- RUN:
  - run_cycles increments every cycle.
  - ps_stop=1 -> DUMP_RD. ps_stop is sampled only in RUN.
  - run_cycles reaching TIMEOUT -> set timeout_err and go to DUMP_RD; the dump still happens for debug.
- Processor port service, in RUN only:
  - im_r_data updates on the falling edge of clk to IM[im_addr] when im_rd=1; otherwise it holds.
  - dm_r_data is registered on the rising edge to DM[dm_addr] when dm_rd=1, giving 1-cycle latency; otherwise it holds.
  - dm_wr writes DM[dm_addr] on the rising edge.
  - Read and write to the same address in the same cycle return the old data.
  - Outside RUN, processor enables are ignored.
- DUMP:
  - DUMP_RD issues a DM read at the dump counter.
  - DUMP_OUT presents out_valid with out_data stable until out_ready.
  - On handshake: increment the counter and return to DUMP_RD, or go to DONE after the last word.
  - Throughput is 1 word per 2 cycles minimum.
  - A zero dump count goes straight to DONE.
- go while busy is ignored. The async reset mid-operation returns the block to IDLE immediately.

Decomposition:
- Shared package ps_boot_pkg: state encoding localparams, clamp helper.
- One sub-module, ps_sp_ram: single-port synchronous-write RAM with a registered read port.
  - DM instantiates it once and arbitrates between host and processor by state.
  - IM instantiates it once with its read port clocked on the falling edge.

Test Plan:
- Load 3 IM words, 2 DM words (A=0x0005, B=0x0002); processor stub stores 7 at DM[0] and raises ps_stop after 20 cycles; dump 2 words -> out_data 0x0007 then 0x0002; run_cycles=20; done=1.
- ld_valid toggled every other cycle during load -> only handshaked words are written; the IM readback matches the sent sequence.
- cfg_dm_words=0 and cfg_dump_words=0 -> LOAD_DM skipped; after ps_stop, DONE in the next cycle with no out_valid.
- ps_stop never asserted, TIMEOUT=50 -> timeout_err=1 at run_cycles=50; dump still occurs; the next go clears timeout_err.
- out_ready held low for 10 cycles in DUMP_OUT -> out_valid and out_data stable; exactly one transfer when out_ready rises.
- rst asserted mid-LOAD_DM -> all outputs 0 and state IDLE; go issued while busy is ignored.

Source files
------------

// File: rtl/ps_boot_pkg.sv
// Shared types and helpers for the ps_boot_ctrl harness: controller state
// encoding and the word-count clamp applied to host configuration.
package ps_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IM,
    ST_LOAD_DM,
    ST_START,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_OUT,
    ST_DONE
  } state_e;

  localparam int RUN_CNT_W = 32;

  // Limits a requested word count to the array depth (2**addr_width).
  function automatic logic [31:0] clamp_words(input logic [31:0] words, input int addr_width);
    logic [31:0] limit;
    limit = 32'd1 << addr_width;
    return (words > limit) ? limit : words;
  endfunction

endpackage

// File: rtl/ps_boot_ctrl_if.sv
// Host stream, status and processor memory-port signals of ps_boot_ctrl.
// slave is the controller's view; master is the host/processor view.
interface ps_boot_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  go;
  logic [ADDR_WIDTH:0]   cfg_im_words;
  logic [ADDR_WIDTH:0]   cfg_dm_words;
  logic [ADDR_WIDTH:0]   cfg_dump_words;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;
  logic [31:0]           run_cycles;
  logic                  ps_start;
  logic                  ps_stop;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_rd;
  logic [DATA_WIDTH-1:0] im_r_data;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic                  dm_rd;
  logic                  dm_wr;
  logic [DATA_WIDTH-1:0] dm_w_data;
  logic [DATA_WIDTH-1:0] dm_r_data;

  modport slave (
    input  go, cfg_im_words, cfg_dm_words, cfg_dump_words,
    input  ld_valid, ld_data, out_ready, ps_stop,
    input  im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
    output ld_ready, out_valid, out_data, busy, done, timeout_err,
    output run_cycles, ps_start, im_r_data, dm_r_data
  );

  modport master (
    output go, cfg_im_words, cfg_dm_words, cfg_dump_words,
    output ld_valid, ld_data, out_ready, ps_stop,
    output im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data,
    input  ld_ready, out_valid, out_data, busy, done, timeout_err,
    input  run_cycles, ps_start, im_r_data, dm_r_data
  );
endinterface

// File: rtl/ps_sp_ram.sv
// Single-port RAM: synchronous write on the rising edge, registered read
// on the rising or (RD_NEGEDGE=1) falling edge. Same-cycle read returns old data.
module ps_sp_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter bit RD_NEGEDGE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros; only the read register is reset.
  // NOTE: non-blocking writes keep a same-edge read returning the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  if (RD_NEGEDGE) begin : g_rd_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)  rdata_q <= '0;
      else if (re) rdata_q <= mem[addr];
    end
  end else begin : g_rd_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata_q <= '0;
      else if (re) rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ps_boot_ctrl.sv
// Boot harness for pipelinedPS: loads IM/DM from the host stream, starts the
// processor, watches for stop under a watchdog, then streams a DM window back.
module ps_boot_ctrl
  import ps_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1000000
) (
  input logic           clk,
  input logic           rst,
  ps_boot_ctrl_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [RUN_CNT_W-1:0] TIMEOUT_C = RUN_CNT_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [CW-1:0]          im_words_q, im_words_d;
  logic [CW-1:0]          dm_words_q, dm_words_d;
  logic [CW-1:0]          dump_words_q, dump_words_d;
  logic [CW-1:0]          ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]          dump_cnt_q, dump_cnt_d;
  logic [RUN_CNT_W-1:0]   run_cycles_q, run_cycles_d;
  logic                   timeout_q, timeout_d;

  logic [CW-1:0]          cfg_im_c, cfg_dm_c, cfg_dump_c;
  logic [CW-1:0]          ld_cnt_inc, dump_cnt_inc;
  logic                   ld_ready, out_valid, ps_start;

  logic                   im_we, im_re;
  logic [ADDR_WIDTH-1:0]  im_addr_m;
  logic [DATA_WIDTH-1:0]  im_rdata;
  logic                   dm_we, dm_re;
  logic [ADDR_WIDTH-1:0]  dm_addr_m;
  logic [DATA_WIDTH-1:0]  dm_wdata_m;
  logic [DATA_WIDTH-1:0]  dm_rdata;

  assign cfg_im_c     = CW'(clamp_words(32'(bus.cfg_im_words), ADDR_WIDTH));
  assign cfg_dm_c     = CW'(clamp_words(32'(bus.cfg_dm_words), ADDR_WIDTH));
  assign cfg_dump_c   = CW'(clamp_words(32'(bus.cfg_dump_words), ADDR_WIDTH));
  assign ld_cnt_inc   = ld_cnt_q + CW'(1);
  assign dump_cnt_inc = dump_cnt_q + CW'(1);

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    im_words_d   = im_words_q;
    dm_words_d   = dm_words_q;
    dump_words_d = dump_words_q;
    ld_cnt_d     = ld_cnt_q;
    dump_cnt_d   = dump_cnt_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    ld_ready     = 1'b0;
    out_valid    = 1'b0;
    ps_start     = 1'b0;
    im_we        = 1'b0;
    im_re        = 1'b0;
    im_addr_m    = ld_cnt_q[ADDR_WIDTH-1:0];
    dm_we        = 1'b0;
    dm_re        = 1'b0;
    dm_addr_m    = ld_cnt_q[ADDR_WIDTH-1:0];
    dm_wdata_m   = bus.ld_data;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.go) begin
          im_words_d   = cfg_im_c;
          dm_words_d   = cfg_dm_c;
          dump_words_d = cfg_dump_c;
          ld_cnt_d     = '0;
          dump_cnt_d   = '0;
          run_cycles_d = '0;
          timeout_d    = 1'b0;
          // Empty load phases are skipped without spending a cycle in them.
          if (cfg_im_c != '0)      state_d = ST_LOAD_IM;
          else if (cfg_dm_c != '0) state_d = ST_LOAD_DM;
          else                     state_d = ST_START;
        end
      end
      ST_LOAD_IM: begin
        ld_ready = 1'b1;
        if (bus.ld_valid) begin
          im_we    = 1'b1;
          ld_cnt_d = ld_cnt_inc;
          if (ld_cnt_inc == im_words_q) begin
            ld_cnt_d = '0;
            state_d  = (dm_words_q != '0) ? ST_LOAD_DM : ST_START;
          end
        end
      end
      ST_LOAD_DM: begin
        ld_ready = 1'b1;
        if (bus.ld_valid) begin
          dm_we    = 1'b1;
          ld_cnt_d = ld_cnt_inc;
          if (ld_cnt_inc == dm_words_q) begin
            ld_cnt_d = '0;
            state_d  = ST_START;
          end
        end
      end
      ST_START: begin
        ps_start = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        im_re        = bus.im_rd;
        im_addr_m    = bus.im_addr;
        dm_re        = bus.dm_rd;
        dm_we        = bus.dm_wr;
        dm_addr_m    = bus.dm_addr;
        dm_wdata_m   = bus.dm_w_data;
        run_cycles_d = (&run_cycles_q) ? run_cycles_q : run_cycles_q + RUN_CNT_W'(1);
        if (run_cycles_d == TIMEOUT_C) timeout_d = 1'b1;
        if (bus.ps_stop || run_cycles_d == TIMEOUT_C)
          state_d = (dump_words_q != '0) ? ST_DUMP_RD : ST_DONE;
      end
      ST_DUMP_RD: begin
        dm_re     = 1'b1;
        dm_addr_m = dump_cnt_q[ADDR_WIDTH-1:0];
        state_d   = ST_DUMP_OUT;
      end
      ST_DUMP_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (dump_cnt_inc == dump_words_q) begin
            state_d = ST_DONE;
          end else begin
            dump_cnt_d = dump_cnt_inc;
            state_d    = ST_DUMP_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      im_words_q   <= '0;
      dm_words_q   <= '0;
      dump_words_q <= '0;
      ld_cnt_q     <= '0;
      dump_cnt_q   <= '0;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      im_words_q   <= im_words_d;
      dm_words_q   <= dm_words_d;
      dump_words_q <= dump_words_d;
      ld_cnt_q     <= ld_cnt_d;
      dump_cnt_q   <= dump_cnt_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
    end
  end

  // IM is read on the falling edge so the processor sees fetch data within its cycle.
  ps_sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_NEGEDGE (1'b1)
  ) u_im (
    .clk   (clk),
    .rst_n (rst),
    .addr  (im_addr_m),
    .we    (im_we),
    .wdata (bus.ld_data),
    .re    (im_re),
    .rdata (im_rdata)
  );

  ps_sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RD_NEGEDGE (1'b0)
  ) u_dm (
    .clk   (clk),
    .rst_n (rst),
    .addr  (dm_addr_m),
    .we    (dm_we),
    .wdata (dm_wdata_m),
    .re    (dm_re),
    .rdata (dm_rdata)
  );

  assign bus.ld_ready    = ld_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = dm_rdata;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.timeout_err = timeout_q;
  assign bus.run_cycles  = run_cycles_q;
  assign bus.ps_start    = ps_start;
  assign bus.im_r_data   = im_rdata;
  assign bus.dm_r_data   = dm_rdata;

endmodule

// File: tb/tb_ps_boot_ctrl.sv
// Self-checking bench for ps_boot_ctrl: randomized jobs checked against an
// array model of IM/DM and the load/run/dump rules of the harness.
module tb_ps_boot_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int CW    = AW + 1;
  localparam int TO    = 50;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps_boot_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ps_boot_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_bad    = 0;

  logic [DW-1:0] im_m [DEPTH];
  logic [DW-1:0] dm_m [DEPTH];
  bit            dm_known [DEPTH];
  logic [DW-1:0] ld_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.go = 1'b0;
    bus.cfg_im_words = '0;
    bus.cfg_dm_words = '0;
    bus.cfg_dump_words = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.out_ready = 1'b0;
    bus.ps_stop = 1'b0;
    bus.im_addr = '0;
    bus.im_rd = 1'b0;
    bus.dm_addr = '0;
    bus.dm_rd = 1'b0;
    bus.dm_wr = 1'b0;
    bus.dm_w_data = '0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
    check({pfx, "_ld_ready"}, bus.ld_ready, 0);
    check({pfx, "_out_valid"}, bus.out_valid, 0);
    check({pfx, "_out_data"}, bus.out_data, 0);
    check({pfx, "_timeout_err"}, bus.timeout_err, 0);
    check({pfx, "_run_cycles"}, bus.run_cycles, 0);
    check({pfx, "_ps_start"}, bus.ps_start, 0);
    check({pfx, "_im_r_data"}, bus.im_r_data, 0);
    check({pfx, "_dm_r_data"}, bus.dm_r_data, 0);
  endtask

  // One complete job: go, load, run (processor stub), dump.
  // stop_after=0 means the processor never stops and the watchdog must fire.
  task automatic run_job(input int cfg_im, input int cfg_dm, input int cfg_dump,
                         input int stop_after, input bit gap, input bit go_busy,
                         input int stall, input bit rand_proc);
    int ni, nd, ndump, total, idx, budget, run_len, w;
    bit vtog, rd_ok;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] a;

    ni    = (cfg_im   > DEPTH) ? DEPTH : cfg_im;
    nd    = (cfg_dm   > DEPTH) ? DEPTH : cfg_dm;
    ndump = (cfg_dump > DEPTH) ? DEPTH : cfg_dump;
    total = ni + nd;
    if (ld_q.size() != total) begin
      ld_q.delete();
      for (int i = 0; i < total; i++) ld_q.push_back(DW'($urandom));
    end

    bus.cfg_im_words   = CW'(cfg_im);
    bus.cfg_dm_words   = CW'(cfg_dm);
    bus.cfg_dump_words = CW'(cfg_dump);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("go_busy", bus.busy, 1);
    check("go_done", bus.done, 0);
    check("go_timeout_clr", bus.timeout_err, 0);
    check("go_run_cycles_clr", bus.run_cycles, 0);

    idx = 0; budget = 0; vtog = 1'b0;
    while (idx < total && budget < 4 * total + 8) begin
      vtog = ~vtog;
      if (gap && !vtog) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = DW'($urandom);
      end else begin
        bus.ld_valid = 1'b1;
        bus.ld_data  = ld_q[idx];
        if (bus.ld_ready) idx++;
      end
      if (go_busy && budget == 1) begin
        bus.go = 1'b1;
        bus.cfg_im_words   = CW'($urandom_range(1, 40));
        bus.cfg_dm_words   = CW'($urandom_range(1, 40));
        bus.cfg_dump_words = CW'($urandom_range(1, 40));
      end else begin
        bus.go = 1'b0;
      end
      tick();
      budget++;
    end
    bus.ld_valid = 1'b0;
    bus.go = 1'b0;
    check("load_words", idx, total);
    for (int i = 0; i < DEPTH; i++) dm_known[i] = 1'b0;
    for (int i = 0; i < ni; i++) im_m[i] = ld_q[i];
    for (int i = 0; i < nd; i++) begin
      dm_m[i] = ld_q[ni + i];
      dm_known[i] = 1'b1;
    end
    ld_q.delete();

    check("start_pulse", bus.ps_start, 1);
    check("start_ld_ready", bus.ld_ready, 0);
    tick();
    check("start_one_cycle", bus.ps_start, 0);

    run_len = (stop_after != 0) ? stop_after : TO;
    for (int c = 1; c <= run_len; c++) begin
      bus.im_rd = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
      if (!rand_proc) begin
        if (c == 1) begin
          bus.dm_wr = 1'b1; bus.dm_addr = '0; bus.dm_w_data = DW'(7);
        end
      end else begin
        if (c - 1 < ni) begin
          bus.im_rd = 1'b1; bus.im_addr = AW'(c - 1);
        end else if (ni > 0 && $urandom_range(1) == 1) begin
          bus.im_rd = 1'b1; bus.im_addr = AW'($urandom_range(ni - 1));
        end
        bus.dm_addr   = AW'($urandom_range(15));
        bus.dm_rd     = 1'($urandom_range(1));
        bus.dm_wr     = 1'($urandom_range(1));
        bus.dm_w_data = DW'($urandom);
      end
      bus.ps_stop = (c == stop_after);
      @(negedge clk);
      #1;
      if (bus.im_rd) check("im_read", bus.im_r_data, im_m[bus.im_addr]);
      a = bus.dm_addr;
      exp_rd = dm_m[a];
      rd_ok = bus.dm_rd && dm_known[a];
      tick();
      if (rd_ok) check("dm_read", bus.dm_r_data, exp_rd);
      if (bus.dm_wr) begin
        dm_m[a] = bus.dm_w_data;
        dm_known[a] = 1'b1;
      end
    end
    bus.ps_stop = 1'b0; bus.im_rd = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;

    check("run_cycles", bus.run_cycles, run_len);
    check("timeout_err", bus.timeout_err, (stop_after == 0));
    check("exit_busy", bus.busy, (ndump != 0));
    check("exit_done", bus.done, (ndump == 0));
    check("exit_no_valid", bus.out_valid, 0);

    for (int i = 0; i < ndump; i++) begin
      w = 0;
      while (!bus.out_valid && w < 4) begin
        tick();
        w++;
      end
      check("dump_latency", w, 1);
      check("dump_valid", bus.out_valid, 1);
      check("dump_data", bus.out_data, dm_m[i]);
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          tick();
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, dm_m[i]);
        end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("dump_one_xfer", bus.out_valid, 0);
    end
    check("end_done", bus.done, 1);
    check("end_busy", bus.busy, 0);
    check("end_timeout_hold", bus.timeout_err, (stop_after == 0));
  endtask

  task automatic reset_mid_load();
    for (int i = 0; i < 6; i++) ld_q.push_back(DW'($urandom));
    bus.cfg_im_words = CW'(2);
    bus.cfg_dm_words = CW'(4);
    bus.cfg_dump_words = CW'(1);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_ld_ready", bus.ld_ready, 1);
      bus.ld_valid = 1'b1;
      bus.ld_data  = ld_q[k];
      tick();
    end
    bus.ld_valid = 1'b0;
    im_m[0] = ld_q[0];
    im_m[1] = ld_q[1];
    dm_m[0] = ld_q[2];
    ld_q.delete();
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_ld_ready", bus.ld_ready, 1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_done", bus.done, 0);
    check("post_rst_ld_ready", bus.ld_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ci, cd;
    idle_inputs();
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_all_zero("idle");

    // Directed: IM 3 words, DM {5,2}; stub stores 7 at DM[0], stops after 20.
    for (int i = 0; i < 3; i++) ld_q.push_back(DW'($urandom));
    ld_q.push_back(DW'(16'h0005));
    ld_q.push_back(DW'(16'h0002));
    run_job(3, 2, 2, 20, 1'b0, 1'b0, 0, 1'b0);
    check("directed_dm0", dm_m[0], 16'h0007);

    run_job(6, 3, 2, 12, 1'b1, 1'b0, 0, 1'b1);
    run_job(4, 0, 0, 8, 1'b0, 1'b0, 0, 1'b1);
    run_job(0, 0, 0, 5, 1'b0, 1'b0, 0, 1'b1);
    run_job(3, 4, 3, 0, 1'b0, 1'b0, 0, 1'b1);
    run_job(2, 3, 2, 10, 1'b0, 1'b0, 10, 1'b1);

    reset_mid_load();
    run_job(5, 3, 3, 15, 1'b0, 1'b1, 0, 1'b1);
    run_job(511, 300, 260, 30, 1'b0, 1'b0, 0, 1'b1);

    for (int j = 0; j < 6; j++) begin
      ci = $urandom_range(24);
      cd = $urandom_range(16);
      run_job(ci, cd, $urandom_range(cd), $urandom_range(1, 45),
              1'($urandom_range(1)), 1'b0, $urandom_range(3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
